// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-memory request arbiter:
// FSM encoding, requester IDs and the default next-level address width.
package cache_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Round-robin choice between the two slots; a tie goes to whoever was not granted last.
  function automatic logic pick_winner(input logic ic_cand, input logic dc_cand,
                                       input logic last_grant);
    logic winner;
    if (ic_cand && dc_cand) begin
      winner = (last_grant == REQ_DC) ? REQ_IC : REQ_DC;
    end else if (ic_cand) begin
      winner = REQ_IC;
    end else begin
      winner = REQ_DC;
    end
    return winner;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction- and data-cache miss requests onto a single next-level
// port with one outstanding transaction, a WAIT timeout and grant statistics.
module mem_req_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_we,
  output logic              dc_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic              mem_done,
  output logic              timeout_err,
  output logic [15:0]       ic_grants,
  output logic [15:0]       dc_grants,
  output arb_state_t        dbg_state
);

  // The counter only has to represent 0 .. MAX_WAIT-1 before the limit fires.
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  arb_state_t        state_q, state_d;
  logic              ic_full_q, dc_full_q;
  logic [ADDR_W-1:0] ic_addr_q, dc_addr_q;
  logic              dc_we_q;
  logic              last_grant_q, owner_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              ic_done_q, dc_done_q, timeout_q;

  logic ic_cand, dc_cand;
  logic grant_any, grant_id;
  logic finish, timed_out;
  logic ic_grant_inc, dc_grant_inc;

  // Handshake: a slot accepts a request on any cycle where valid && ready;
  // ready is simply "slot empty", so it never depends on valid in the same cycle.
  assign ic_req_ready = ~ic_full_q;
  assign dc_req_ready = ~dc_full_q;

  // A slot whose done pulse is in flight is being freed and must not be re-granted.
  assign ic_cand = ic_full_q & ~ic_done_q;
  assign dc_cand = dc_full_q & ~dc_done_q;

  always_comb begin
    state_d   = state_q;
    grant_any = 1'b0;
    grant_id  = last_grant_q;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ic_cand || dc_cand) begin
          grant_any = 1'b1;
          grant_id  = pick_winner(ic_cand, dc_cand, last_grant_q);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          if (mem_done) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ic_full_q    <= 1'b0;
      dc_full_q    <= 1'b0;
      ic_addr_q    <= '0;
      dc_addr_q    <= '0;
      dc_we_q      <= 1'b0;
      last_grant_q <= REQ_DC;
      owner_q      <= REQ_IC;
      wait_cnt_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      ic_done_q    <= 1'b0;
      dc_done_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (ic_req_valid && ic_req_ready) begin
        ic_full_q <= 1'b1;
        ic_addr_q <= ic_addr;
      end else if (ic_done_q) begin
        ic_full_q <= 1'b0;
      end

      if (dc_req_valid && dc_req_ready) begin
        dc_full_q <= 1'b1;
        dc_addr_q <= dc_addr;
        dc_we_q   <= dc_we;
      end else if (dc_done_q) begin
        dc_full_q <= 1'b0;
      end

      // Request fields are loaded once at grant and held until the slot is reused.
      if (grant_any) begin
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
        mem_req_q    <= 1'b1;
        mem_addr_q   <= (grant_id == REQ_IC) ? ic_addr_q : dc_addr_q;
        mem_we_q     <= (grant_id == REQ_DC) & dc_we_q;
      end else if ((state_q == ST_ISSUE) && mem_ack) begin
        mem_req_q <= 1'b0;
      end

      if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
        wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      ic_done_q <= finish & (owner_q == REQ_IC);
      dc_done_q <= finish & (owner_q == REQ_DC);
      timeout_q <= timeout_q | timed_out;
    end
  end

  assign ic_grant_inc = grant_any & (grant_id == REQ_IC);
  assign dc_grant_inc = grant_any & (grant_id == REQ_DC);

  sat_counter #(.W(16)) u_ic_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ic_grant_inc),
    .count (ic_grants)
  );

  sat_counter #(.W(16)) u_dc_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dc_grant_inc),
    .count (dc_grants)
  );

  assign ic_done     = ic_done_q;
  assign dc_done     = dc_done_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign timeout_err = timeout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: cycle-by-cycle vector table plus
// hand-written timeout, reset and counter-saturation sequences.
module tb_mem_req_arbiter;
  import cache_pkg::*;

  localparam logic hi = 1'b1;
  localparam logic lo = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req_valid = 1'b0, dc_req_valid = 1'b0, dc_we = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0;
  logic        mem_ack = 1'b0, mem_done = 1'b0;
  logic        ic_req_ready, dc_req_ready, ic_done, dc_done;
  logic        mem_req, mem_we, timeout_err;
  logic [31:0] mem_addr;
  logic [15:0] ic_grants, dc_grants;
  arb_state_t  dbg_state;

  logic        sat_rst_n = 1'b0, sat_inc = 1'b0;
  logic [7:0]  sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic        sb_on = 1'b0;
  logic        req_prev = 1'b0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(32), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ic_req_valid (ic_req_valid),
    .ic_req_ready (ic_req_ready),
    .ic_addr      (ic_addr),
    .ic_done      (ic_done),
    .dc_req_valid (dc_req_valid),
    .dc_req_ready (dc_req_ready),
    .dc_addr      (dc_addr),
    .dc_we        (dc_we),
    .dc_done      (dc_done),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .mem_done     (mem_done),
    .timeout_err  (timeout_err),
    .ic_grants    (ic_grants),
    .dc_grants    (dc_grants),
    .dbg_state    (dbg_state)
  );

  // Same counter module at a narrow width so the saturation point is reachable quickly.
  sat_counter #(.W(8)) u_sat8 (
    .clk   (clk),
    .rst_n (sat_rst_n),
    .inc   (sat_inc),
    .count (sat_count)
  );

  typedef struct {
    logic        ic_v;
    logic [31:0] ic_a;
    logic        dc_v;
    logic [31:0] dc_a;
    logic        we;
    logic        ack;
    logic        done;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic        e_icd;
    logic        e_dcd;
    logic        e_icr;
    logic        e_dcr;
    arb_state_t  e_st;
    logic [15:0] e_icg;
    logic [15:0] e_dcg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ic_v, input logic [31:0] ic_a, input logic dc_v,
                              input logic [31:0] dc_a, input logic we, input logic ack,
                              input logic done, input logic e_req, input logic [31:0] e_addr,
                              input logic e_we, input logic e_icd, input logic e_dcd,
                              input logic e_icr, input logic e_dcr, input arb_state_t e_st,
                              input logic [15:0] e_icg, input logic [15:0] e_dcg);
    vec_t v;
    v.ic_v = ic_v;   v.ic_a = ic_a;     v.dc_v = dc_v;   v.dc_a = dc_a;
    v.we = we;       v.ack = ack;       v.done = done;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we;
    v.e_icd = e_icd; v.e_dcd = e_dcd;   v.e_icr = e_icr; v.e_dcr = e_dcr;
    v.e_st = e_st;   v.e_icg = e_icg;   v.e_dcg = e_dcg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    dc_we        = 1'b0;
    mem_ack      = 1'b0;
    mem_done     = 1'b0;
  endtask

  // Scoreboard: every new next-level request must carry the next expected address.
  always @(negedge clk) begin
    if (sb_on && mem_req && !req_prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_req: got addr 0x%0h, expected no request", mem_addr);
      end else begin
        logic [31:0] exp_a;
        exp_a = exp_q.pop_front();
        if (mem_addr !== exp_a) begin
          n_fail++;
          $display("FAIL sb_addr: got 0x%0h, expected 0x%0h", mem_addr, exp_a);
        end
      end
    end
    req_prev = mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: ic_v ic_a dc_v dc_a we ack done | req addr we icd dcd icr dcr state icg dcg
    tbl.push_back(mk(hi, 32'h0000_1040, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, lo, hi, ST_IDLE, 16'd0, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_1040, lo, lo, lo, lo, hi, ST_ISSUE, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_1040, lo, lo, lo, lo, hi, ST_ISSUE, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, lo, lo, 32'h0, lo, lo, lo, lo, hi, ST_WAIT, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, lo, hi, ST_WAIT, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, lo, hi, ST_WAIT, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, hi, lo, 32'h0, lo, hi, lo, lo, hi, ST_IDLE, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, hi, hi, ST_IDLE, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, hi, 32'h00FF_0000, hi, lo, lo, lo, 32'h0, lo, lo, lo, hi, lo, ST_IDLE, 16'd1, 16'd0));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h00FF_0000, hi, lo, lo, hi, lo, ST_ISSUE, 16'd1, 16'd1));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, lo, hi, hi, lo, ST_IDLE, 16'd1, 16'd1));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, hi, hi, ST_IDLE, 16'd1, 16'd1));
    tbl.push_back(mk(hi, 32'h0000_2000, hi, 32'h0000_3000, lo, lo, lo, lo, 32'h0, lo, lo, lo, lo, lo, ST_IDLE, 16'd1, 16'd1));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_2000, lo, lo, lo, lo, lo, ST_ISSUE, 16'd2, 16'd1));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, hi, lo, lo, lo, ST_IDLE, 16'd2, 16'd1));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_3000, lo, lo, lo, hi, lo, ST_ISSUE, 16'd2, 16'd2));
    tbl.push_back(mk(hi, 32'h0000_2040, lo, 32'h0, lo, lo, lo, hi, 32'h0000_3000, lo, lo, lo, lo, lo, ST_ISSUE, 16'd2, 16'd2));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, lo, hi, lo, lo, ST_IDLE, 16'd2, 16'd2));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_2040, lo, lo, lo, lo, hi, ST_ISSUE, 16'd3, 16'd2));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, hi, lo, lo, hi, ST_IDLE, 16'd3, 16'd2));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, hi, hi, ST_IDLE, 16'd3, 16'd2));
    tbl.push_back(mk(hi, 32'h0000_2080, hi, 32'h0000_3040, hi, lo, lo, lo, 32'h0, lo, lo, lo, lo, lo, ST_IDLE, 16'd3, 16'd2));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_3040, hi, lo, lo, lo, lo, ST_ISSUE, 16'd3, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, lo, hi, lo, lo, ST_IDLE, 16'd3, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, hi, 32'h0000_2080, lo, lo, lo, lo, hi, ST_ISSUE, 16'd4, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, lo, lo, 32'h0, lo, lo, lo, lo, hi, ST_WAIT, 16'd4, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, hi, lo, 32'h0, lo, hi, lo, lo, hi, ST_IDLE, 16'd4, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, lo, lo, lo, 32'h0, lo, lo, lo, hi, hi, ST_IDLE, 16'd4, 16'd3));
    tbl.push_back(mk(lo, 32'h0, lo, 32'h0, lo, hi, hi, lo, 32'h0, lo, lo, lo, hi, hi, ST_IDLE, 16'd4, 16'd3));

    // Reset state
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst ic_ready", 32'(ic_req_ready), 32'd1);
    check("rst dc_ready", 32'(dc_req_ready), 32'd1);
    check("rst timeout", 32'(timeout_err), 32'd0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Vector table
    sb_on = 1'b1;
    begin
      logic prev_e_req;
      prev_e_req = 1'b0;
      foreach (tbl[i]) begin
        ic_req_valid = tbl[i].ic_v;
        ic_addr      = tbl[i].ic_a;
        dc_req_valid = tbl[i].dc_v;
        dc_addr      = tbl[i].dc_a;
        dc_we        = tbl[i].we;
        mem_ack      = tbl[i].ack;
        mem_done     = tbl[i].done;
        if (tbl[i].e_req && !prev_e_req) exp_q.push_back(tbl[i].e_addr);
        prev_e_req = tbl[i].e_req;
        step();
        check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
        if (tbl[i].e_req) begin
          check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
          check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
        end
        check($sformatf("v%0d ic_done", i), 32'(ic_done), 32'(tbl[i].e_icd));
        check($sformatf("v%0d dc_done", i), 32'(dc_done), 32'(tbl[i].e_dcd));
        check($sformatf("v%0d ic_ready", i), 32'(ic_req_ready), 32'(tbl[i].e_icr));
        check($sformatf("v%0d dc_ready", i), 32'(dc_req_ready), 32'(tbl[i].e_dcr));
        check($sformatf("v%0d state", i), 32'(dbg_state), 32'(tbl[i].e_st));
        check($sformatf("v%0d ic_grants", i), 32'(ic_grants), 32'(tbl[i].e_icg));
        check($sformatf("v%0d dc_grants", i), 32'(dc_grants), 32'(tbl[i].e_dcg));
        check($sformatf("v%0d timeout", i), 32'(timeout_err), 32'd0);
      end
    end
    drive_idle();
    @(negedge clk);
    sb_on = 1'b0;
    #1;
    check("sb queue drained", 32'(exp_q.size()), 32'd0);

    // Timeout: mem_done withheld for MAX_WAIT=8 WAIT cycles
    ic_req_valid = 1'b1;
    ic_addr      = 32'h0000_5000;
    step();
    ic_req_valid = 1'b0;
    step();
    check("to issue addr", mem_addr, 32'h0000_5000);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("to wait%0d state", k), 32'(dbg_state), 32'(ST_WAIT));
      check($sformatf("to wait%0d flag", k), 32'(timeout_err), 32'd0);
      step();
    end
    check("to flag set", 32'(timeout_err), 32'd1);
    check("to ic_done", 32'(ic_done), 32'd1);
    check("to state idle", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check("to flag sticky", 32'(timeout_err), 32'd1);
    check("to done one cycle", 32'(ic_done), 32'd0);
    check("to slot freed", 32'(ic_req_ready), 32'd1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check("late done ignored ic", 32'(ic_done), 32'd0);
    check("late done ignored dc", 32'(dc_done), 32'd0);
    check("to flag still set", 32'(timeout_err), 32'd1);

    // Reset during WAIT with the other requester still pending
    ic_req_valid = 1'b1;
    ic_addr      = 32'h0000_7000;
    dc_req_valid = 1'b1;
    dc_addr      = 32'h0000_6000;
    dc_we        = 1'b1;
    step();
    drive_idle();
    step();
    check("rw tie after ic -> dc", mem_addr, 32'h0000_6000);
    check("rw mem_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rw in wait", 32'(dbg_state), 32'(ST_WAIT));
    rst_n = 1'b0;
    step();
    check("rw mem_req", 32'(mem_req), 32'd0);
    check("rw mem_addr", mem_addr, 32'd0);
    check("rw mem_we zero", 32'(mem_we), 32'd0);
    check("rw ic_done", 32'(ic_done), 32'd0);
    check("rw dc_done", 32'(dc_done), 32'd0);
    check("rw timeout cleared", 32'(timeout_err), 32'd0);
    check("rw ic_grants", 32'(ic_grants), 32'd0);
    check("rw dc_grants", 32'(dc_grants), 32'd0);
    check("rw ic_ready", 32'(ic_req_ready), 32'd1);
    check("rw dc_ready", 32'(dc_req_ready), 32'd1);
    rst_n    = 1'b1;
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check("rw no dc_done", 32'(dc_done), 32'd0);
    check("rw no ic_done", 32'(ic_done), 32'd0);
    check("rw idle", 32'(dbg_state), 32'(ST_IDLE));

    // First tie after reset goes to IC
    ic_req_valid = 1'b1;
    ic_addr      = 32'h0000_7100;
    dc_req_valid = 1'b1;
    dc_addr      = 32'h0000_6100;
    step();
    drive_idle();
    step();
    check("post-rst tie addr", mem_addr, 32'h0000_7100);
    check("post-rst ic_grants", 32'(ic_grants), 32'd1);
    check("post-rst dc_grants", 32'(dc_grants), 32'd0);
    mem_ack  = 1'b1;
    mem_done = 1'b1;
    step();
    drive_idle();
    check("post-rst ic_done", 32'(ic_done), 32'd1);

    // Saturating counter
    sat_rst_n = 1'b1;
    sat_inc   = 1'b1;
    repeat (10) step();
    check("sat count 10", 32'(sat_count), 32'd10);
    repeat (290) step();
    check("sat holds max", 32'(sat_count), 32'd255);
    sat_inc = 1'b0;
    step();
    check("sat idle max", 32'(sat_count), 32'd255);
    sat_rst_n = 1'b0;
    step();
    check("sat clear", 32'(sat_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, next-level address width.
REQ-002 SHALL have parameter MAX_WAIT, default 255, the WAIT-state cycle limit before timeout.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports ic_req_valid (input, 1), ic_req_ready (output, 1) and ic_addr (input, ADDR_W): instruction-cache miss request.
REQ-006 SHALL have port ic_done  output  1  one-cycle completion pulse to the instruction cache.
REQ-007 SHALL have ports dc_req_valid (input, 1), dc_req_ready (output, 1), dc_addr (input, ADDR_W) and dc_we (input, 1): data-cache request, with write flag.
REQ-008 SHALL have port dc_done  output  1  one-cycle completion pulse to the data cache.
REQ-009 SHALL have ports mem_req (output, 1), mem_addr (output, ADDR_W) and mem_we (output, 1): request to next level.
REQ-010 SHALL have ports mem_ack (input, 1, next level accepted request) and mem_done (input, 1, next level completed transaction).
REQ-011 SHALL have port timeout_err  output  1  sticky timeout flag.
REQ-012 SHALL have ports ic_grants and dc_grants (output, 16 each): saturating grant counters for the statistics module.

Function
REQ-013 SHALL hold one slot per requester; req_ready = slot empty; valid&ready captures the address (and dc_we) and marks the slot full.
REQ-014 SHALL run FSM states IDLE, ISSUE, WAIT; at most one next-level transaction is outstanding.
REQ-015 In IDLE with at least one full slot, SHALL grant a requester and go to ISSUE next cycle; with one full slot, grant that slot.
REQ-016 With both slots full, SHALL grant the requester not granted last; last_grant resets to DC, so IC wins the first tie.
REQ-017 In ISSUE, SHALL drive mem_req=1 and mem_addr/mem_we from the granted slot, stable until mem_ack; mem_we is always 0 for an IC grant.
REQ-018 On mem_ack in ISSUE, SHALL go to WAIT; mem_req=0 from the following cycle.
REQ-019 If mem_ack and mem_done assert in the same ISSUE cycle, SHALL treat it as completion and go directly to IDLE.
REQ-020 On mem_done in WAIT (or per REQ-019), SHALL pulse the owner's done for exactly one cycle, free the owner's slot, and return to IDLE.
REQ-021 A freed slot's req_ready SHALL be high the cycle after the done pulse.
REQ-022 SHALL ignore mem_done outside ISSUE/WAIT and mem_ack outside ISSUE.
REQ-023 The WAIT counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-024 If the WAIT counter reaches MAX_WAIT without mem_done, SHALL set timeout_err (cleared only by reset), pulse the owner's done, free the slot and return to IDLE.
REQ-025 Latency SHALL be: capture at cycle 0, IDLE arbitration at cycle 1, mem_req high at cycle 2; IDLE lasts at least one cycle between transactions.
REQ-026 SHALL increment ic_grants/dc_grants on each ISSUE entry for that requester, saturating at 0xFFFF.
REQ-027 A new request from the other requester during a transaction SHALL be captured without disturbing mem_* outputs.

Reset
REQ-028 While rst_n=0 at a clock edge, SHALL set: state IDLE; both slots empty; last_grant=DC; counters, timeout_err, mem_req, mem_we, ic_done, dc_done = 0; mem_addr = 0.
REQ-029 Reset mid-transaction SHALL drop all pending and outstanding requests with no done pulse.

Structure
REQ-030 Shared package cache_pkg SHALL hold the FSM state encoding, the requester ID constants (REQ_IC=0, REQ_DC=1) and the default ADDR_W.
REQ-031 SHALL instantiate sub-module sat_counter (16-bit, saturating, synchronous active-low clear) twice for the grant counters.

Verification
REQ-032 IC request at 0x0000_1040 only, mem_ack at cycle 3, mem_done at cycle 6 -> mem_req high cycles 2-3, mem_we=0, ic_done pulse at cycle 7, ic_grants=1.
REQ-033 IC and DC valid in the same cycle -> IC granted first; DC granted after ic_done; repeated both-full state alternates IC, DC, IC.
REQ-034 DC write to 0x00FF_0000 with mem_ack and mem_done in the same cycle -> IDLE next cycle, mem_we=1 during ISSUE, one dc_done pulse.
REQ-035 mem_done withheld, MAX_WAIT=8 -> timeout_err=1 after 8 WAIT cycles, owner done pulse, FSM IDLE, timeout_err stays 1 afterwards.
REQ-036 rst_n=0 during WAIT -> all outputs 0 next cycle, no done pulse, both req_ready=1.
REQ-037 70000 IC transactions -> ic_grants holds at 0xFFFF.
